// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin N-channel request/ack arbiter in front of the byte-wide SDRAM controller
// Optional feature macro: ARB_LOCK_EN (lock forces grants to channel 0 while high)
module sdram_port_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic [NUM_CH-1:0]            ack,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic                         busy,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  input  logic                         lock,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  output logic                         mem_we,
  output logic                         mem_rd,
  input  logic [DATA_WIDTH-1:0]        mem_dout,
  input  logic                         mem_ready
);

  localparam int            CW      = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t                       state_q;
  logic [NUM_CH-1:0]            ack_q;
  logic [NUM_CH*DATA_WIDTH-1:0] dout_q;
  logic                         busy_q;
  logic [CW-1:0]                grant_q;
  logic [CW-1:0]                rr_q;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [DATA_WIDTH-1:0]        din_q;
  logic                         we_q;
  logic                         mem_we_q;
  logic                         mem_rd_q;
  logic                         locked_q;

  logic [CW-1:0] rr_id;
  logic          rr_vld;
  logic [CW-1:0] cand;
  logic [CW-1:0] pick_id_d;
  logic          pick_vld_d;
  logic          pick_lock_d;

  // Round-robin search: walk from the highest offset down so the channel closest to rr_q wins
  always_comb begin
    rr_id  = '0;
    rr_vld = 1'b0;
    cand   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CW'((int'(rr_q) + i) % NUM_CH);
      if (req[cand]) begin
        rr_vld = 1'b1;
        rr_id  = cand;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Lock hands the port to channel 0 only; such grants do not move the rr pointer
  assign pick_lock_d = lock;
  assign pick_vld_d  = lock ? req[0] : rr_vld;
  assign pick_id_d   = lock ? '0 : rr_id;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign pick_lock_d = 1'b0;
  assign pick_vld_d  = rr_vld;
  assign pick_id_d   = rr_id;
`endif

  // Access FSM: IDLE grants and latches, BUSY holds the strobe until mem_ready, ACK pulses ack
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ack_q    <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      rr_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      mem_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            grant_q  <= pick_id_d;
            locked_q <= pick_lock_d;
            addr_q   <= addr[pick_id_d*ADDR_WIDTH +: ADDR_WIDTH];
            din_q    <= din[pick_id_d*DATA_WIDTH +: DATA_WIDTH];
            we_q     <= we[pick_id_d];
            mem_we_q <= we[pick_id_d];
            mem_rd_q <= ~we[pick_id_d];
            busy_q   <= 1'b1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            mem_rd_q <= 1'b0;
            if (!we_q) begin
              dout_q[grant_q*DATA_WIDTH +: DATA_WIDTH] <= mem_dout;
            end
            ack_q[grant_q] <= 1'b1;
            state_q        <= S_ACK;
          end
        end
        S_ACK: begin
          busy_q <= 1'b0;
          if (!locked_q) begin
            rr_q <= (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = mem_we_q;
  assign mem_rd   = mem_rd_q;

endmodule
